// File: rtl/fetch_unit_if.sv
// Fetch-stage bus: pipeline control in, instruction-memory port and IF/ID latch out.
interface fetch_unit_if;
  logic        stall;
  logic        flush;
  logic        branch_taken;
  logic [15:0] branch_tgt;
  logic [15:0] im_instr;
  logic [15:0] iaddr;
  logic        rd_en;
  logic [15:0] if_id_instr;
  logic [15:0] if_id_pc_inc;
  logic        if_id_valid;
  logic        halted;

  modport master (
    input  stall, flush, branch_taken, branch_tgt, im_instr,
    output iaddr, rd_en, if_id_instr, if_id_pc_inc, if_id_valid, halted
  );

  modport slave (
    output stall, flush, branch_taken, branch_tgt, im_instr,
    input  iaddr, rd_en, if_id_instr, if_id_pc_inc, if_id_valid, halted
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC register, IF/ID pipeline latch and a RUN/HALT state machine.
module fetch_unit #(
  parameter logic [15:0] RESET_PC  = 16'h0000,
  parameter logic [15:0] NOP_INSTR = 16'h0000,
  parameter logic [3:0]  HLT_OPC   = 4'hF
) (
  input  logic         clk,
  input  logic         rst_n,
  fetch_unit_if.master bus
);

  typedef enum logic [0:0] {StRun, StHalt} state_e;

  state_e      state_q;
  logic [15:0] pc_q;
  logic [15:0] pc_inc;
  logic [15:0] if_id_instr_q;
  logic [15:0] if_id_pc_inc_q;
  logic        if_id_valid_q;

  assign pc_inc = pc_q + 16'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= StRun;
      pc_q           <= RESET_PC;
      if_id_instr_q  <= NOP_INSTR;
      if_id_pc_inc_q <= 16'h0000;
      if_id_valid_q  <= 1'b0;
    end else if (bus.branch_taken) begin
      // Redirect wins over everything, including leaving HALT.
      state_q       <= StRun;
      pc_q          <= bus.branch_tgt;
      if_id_instr_q <= NOP_INSTR;
      if_id_valid_q <= 1'b0;
    end else if (state_q == StHalt) begin
      if_id_instr_q <= NOP_INSTR;
      if_id_valid_q <= 1'b0;
    end else if (bus.flush) begin
      if_id_instr_q <= NOP_INSTR;
      if_id_valid_q <= 1'b0;
      if (!bus.stall) pc_q <= pc_inc;
    end else if (!bus.stall) begin
      if_id_instr_q  <= bus.im_instr;
      if_id_pc_inc_q <= pc_inc;
      if_id_valid_q  <= 1'b1;
      // A captured halt freezes the PC on its own address.
      if (bus.im_instr[15:12] == HLT_OPC) state_q <= StHalt;
      else                                pc_q    <= pc_inc;
    end
  end

  assign bus.iaddr        = pc_q;
  assign bus.rd_en        = rst_n && (state_q == StRun) && !bus.stall;
  assign bus.if_id_instr  = if_id_instr_q;
  assign bus.if_id_pc_inc = if_id_pc_inc_q;
  assign bus.if_id_valid  = if_id_valid_q;
  assign bus.halted       = (state_q == StHalt);

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 16'h0000, PC value loaded on reset.
REQ-002 Parameter NOP_INSTR, default 16'h0000, instruction word inserted into IF/ID on flush/redirect.
REQ-003 Parameter HLT_OPC, default 4'hF, opcode (instr[15:12]) identifying halt.
REQ-004 clk  input  1  system clock; fetch state and IF/ID update on posedge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 stall  input  1  hazard stall; hold PC and IF/ID.
REQ-007 flush  input  1  kill instruction being captured into IF/ID.
REQ-008 branch_taken  input  1  redirect PC to branch_tgt.
REQ-009 branch_tgt  input  16  redirect target address.
REQ-010 im_instr  input  16  instruction word from instruction memory (valid after negedge of current cycle).
REQ-011 iaddr  output  16  fetch address to instruction memory.
REQ-012 rd_en  output  1  instruction memory read enable.
REQ-013 if_id_instr  output  16  registered instruction to decode.
REQ-014 if_id_pc_inc  output  16  registered PC+1 of that instruction.
REQ-015 if_id_valid  output  1  IF/ID holds a real instruction.
REQ-016 halted  output  1  fetch stopped on HLT.

Function
REQ-017 iaddr SHALL equal the PC register combinationally; memory returns im_instr in the same cycle (negedge read), captured on the following posedge.
REQ-018 rd_en SHALL be 1 in RUN state when stall=0, else 0.
REQ-019 States: RUN, HALT; reset enters RUN.
REQ-020 Posedge priority: branch_taken > flush > stall > normal.
REQ-021 branch_taken=1 (either state): PC <= branch_tgt; IF/ID <= {NOP_INSTR, valid=0}; state <= RUN; stall and flush ignored that cycle.
REQ-022 flush=1, branch_taken=0: IF/ID <= {NOP_INSTR, valid=0}; PC holds if stall=1, else PC <= PC+1; HLT detection suppressed.
REQ-023 stall=1, branch_taken=0, flush=0: PC, IF/ID, state unchanged.
REQ-024 Normal RUN: if_id_instr <= im_instr, if_id_pc_inc <= PC+1, if_id_valid <= 1, PC <= PC+1.
REQ-025 Normal RUN with im_instr[15:12]==HLT_OPC: IF/ID captures HLT (valid=1); PC holds; state <= HALT.
REQ-026 HALT: PC held, rd_en=0, IF/ID <= {NOP_INSTR, valid=0} each cycle after the HLT is captured; stall and flush have no effect; only branch_taken or reset leaves HALT.
REQ-027 halted SHALL equal (state==HALT).
REQ-028 PC+1 SHALL be 16-bit modulo: 16'hFFFF wraps to 16'h0000 with no flag.
REQ-029 if_id_pc_inc SHALL be computed from the PC that addressed the captured instruction, not the updated PC.

Reset
REQ-030 rst_n=0 SHALL immediately (asynchronously) set PC=RESET_PC, state=RUN, if_id_instr=NOP_INSTR, if_id_pc_inc=16'h0000, if_id_valid=0, halted=0.
REQ-031 rd_en SHALL be 0 while rst_n=0; first fetch occurs in the first cycle after rst_n rises, with iaddr=RESET_PC.
REQ-032 Reset asserted mid-stall, mid-redirect or in HALT SHALL override all inputs.

Verification
REQ-033 Sequential fetch: reset release, memory 0..3 = 16'h1111,2222,3333,4444 -> IF/ID valid with 1111/pc_inc 0001, then 2222/0002, 3333/0003 on successive posedges.
REQ-034 Stall: assert stall 2 cycles while PC=0002 -> iaddr stays 0002, rd_en=0, IF/ID holds 2222/0002; release -> 3333/0003 next.
REQ-035 Branch vs stall: branch_taken=1, branch_tgt=16'h0100, stall=1 same cycle -> next iaddr=0100, if_id_valid=0; following cycle IF/ID holds mem[0100]/pc_inc 0101.
REQ-036 Halt: mem[0005]=16'hF000 -> IF/ID gets F000 valid, halted=1, iaddr stays 0005, rd_en=0, if_id_valid=0 next cycle; then branch_taken to 0010 -> halted=0, fetch resumes at 0010.
REQ-037 Flush of HLT: flush=1 while im_instr=16'hF000 -> if_id_valid=0, halted stays 0, PC advances.
REQ-038 Wrap and async reset: branch to FFFF -> pc_inc FFFF+1 = 0000, next iaddr 0000; drop rst_n mid-cycle -> outputs reach reset values before next posedge.
